// File: rtl/tcpc_pkg.sv
// Shared definitions for the TCPC I2C slave front end: bus/register widths
// and the transaction FSM state encoding.
package tcpc_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int REG_ADDR_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RFETCH,
    ST_RSHIFT,
    ST_RMACK,
    ST_IGNORE
  } state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchroniser for SCL/SDA plus a delayed copy, giving SCL edge
// strobes and START/STOP detection in the CLK domain.
module i2c_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  // [0] first sync flop, [1] synchronised value, [2] previous synchronised value
  logic [2:0] r_scl_pipe;
  logic [2:0] r_sda_pipe;

  // Idle bus is high, so reset to 1 to avoid a false edge after reset
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_scl_pipe <= '1;
      r_sda_pipe <= '1;
    end else begin
      r_scl_pipe <= {r_scl_pipe[1:0], i_scl};
      r_sda_pipe <= {r_sda_pipe[1:0], i_sda};
    end
  end

  assign o_sda      = r_sda_pipe[1];
  assign o_scl_rise = r_scl_pipe[1] & ~r_scl_pipe[2];
  assign o_scl_fall = ~r_scl_pipe[1] & r_scl_pipe[2];
  assign o_start    = r_scl_pipe[1] & r_scl_pipe[2] & r_sda_pipe[2] & ~r_sda_pipe[1];
  assign o_stop     = r_scl_pipe[1] & r_scl_pipe[2] & ~r_sda_pipe[2] & r_sda_pipe[1];

endmodule

// File: rtl/tcpc_i2c_slave.sv
// I2C slave front end for the TCPC register file: turns bus transactions into
// single-byte register accesses with an auto-incrementing register pointer.
module tcpc_i2c_slave
  import tcpc_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h50,
  parameter int                    ACK_TIMEOUT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_scl,
  input  logic                  i_sda,
  output logic                  o_sda_oe,
  output logic                  o_request,
  output logic                  o_rnw,
  output logic [REG_ADDR_W-1:0] o_addr,
  output logic [7:0]            o_wr_data,
  input  logic [7:0]            i_rd_data,
  input  logic                  i_ack,
  output logic                  o_busy,
  output logic                  o_err_miss
);

  localparam int TMO_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT);

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;

  i2c_sync_edge u_sync (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_scl      (i_scl),
    .i_sda      (i_sda),
    .o_sda      (w_sda),
    .o_scl_rise (w_scl_rise),
    .o_scl_fall (w_scl_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  state_t                  r_state, w_state_next;
  logic [2:0]              r_bit_cnt, w_bit_cnt_next;
  logic [7:0]              r_shift, w_shift_next;
  logic [REG_ADDR_W-1:0]   r_ptr, w_ptr_next;
  logic                    r_sda_oe, w_sda_oe_next;
  logic                    r_mack, w_mack_next;
  logic                    r_rd_mode, w_rd_mode_next;
  logic                    r_request, r_rnw, r_pend, r_err_miss;
  logic [REG_ADDR_W-1:0]   r_addr;
  logic [7:0]              r_wr_data;
  logic [TMO_W-1:0]        r_tmo_cnt;
  logic                    w_issue, w_issue_rnw, w_ack_ok, w_tmo, w_done;
  logic [7:0]              w_byte, w_rdata;

  assign w_byte   = {r_shift[6:0], w_sda};
  assign w_ack_ok = r_pend & i_ack;
  assign w_tmo    = r_pend & ~i_ack & (r_tmo_cnt == TMO_W'(ACK_TIMEOUT - 1));
  assign w_done   = w_ack_ok | w_tmo;
  // A missed read returns zero to the bus master
  assign w_rdata  = w_ack_ok ? i_rd_data : 8'h00;

  always_comb begin
    w_state_next   = r_state;
    w_bit_cnt_next = r_bit_cnt;
    w_shift_next   = r_shift;
    w_ptr_next     = r_ptr;
    w_sda_oe_next  = r_sda_oe;
    w_mack_next    = r_mack;
    w_rd_mode_next = r_rd_mode;
    w_issue        = 1'b0;
    w_issue_rnw    = 1'b0;
    if (w_start) begin
      w_state_next   = ST_DEV_ADDR;
      w_bit_cnt_next = 3'd0;
      w_sda_oe_next  = 1'b0;
    end else if (w_stop) begin
      w_state_next  = ST_IDLE;
      w_sda_oe_next = 1'b0;
    end else begin
      case (r_state)
        ST_DEV_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_next   = w_byte;
            w_bit_cnt_next = r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              if (r_state == ST_DEV_ADDR) begin
                w_rd_mode_next = w_byte[0];
                w_state_next   = (w_byte[7:1] == SLAVE_ADDR) ? ST_DEV_ACK : ST_IGNORE;
              end else if (r_state == ST_PTR) begin
                w_ptr_next   = w_byte;
                w_state_next = ST_PTR_ACK;
              end else begin
                w_issue      = 1'b1;
                w_ptr_next   = r_ptr + 1'b1;
                w_state_next = ST_WDATA_ACK;
              end
            end
          end
        end
        // First SCL fall drives the ACK, the next one ends the ACK clock
        ST_DEV_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (!r_sda_oe) begin
              w_sda_oe_next = 1'b1;
            end else begin
              w_sda_oe_next  = 1'b0;
              w_bit_cnt_next = 3'd0;
              if (r_state != ST_DEV_ACK) begin
                w_state_next = ST_WDATA;
              end else if (r_rd_mode) begin
                w_issue      = 1'b1;
                w_issue_rnw  = 1'b1;
                w_state_next = ST_RFETCH;
              end else begin
                w_state_next = ST_PTR;
              end
            end
          end
        end
        ST_RFETCH: begin
          if (w_done) begin
            w_shift_next   = w_rdata;
            w_sda_oe_next  = ~w_rdata[7];
            w_ptr_next     = r_ptr + 1'b1;
            w_bit_cnt_next = 3'd0;
            w_state_next   = ST_RSHIFT;
          end
        end
        ST_RSHIFT: begin
          if (w_scl_fall) begin
            if (r_bit_cnt == 3'd7) begin
              w_sda_oe_next = 1'b0;
              w_state_next  = ST_RMACK;
            end else begin
              w_shift_next   = {r_shift[6:0], 1'b0};
              w_sda_oe_next  = ~r_shift[6];
              w_bit_cnt_next = r_bit_cnt + 3'd1;
            end
          end
        end
        ST_RMACK: begin
          if (w_scl_rise) begin
            w_mack_next = ~w_sda;
          end else if (w_scl_fall) begin
            if (r_mack) begin
              w_issue      = 1'b1;
              w_issue_rnw  = 1'b1;
              w_state_next = ST_RFETCH;
            end else begin
              w_state_next = ST_IGNORE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= 3'd0;
      r_shift    <= 8'h00;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_mack     <= 1'b0;
      r_rd_mode  <= 1'b0;
      r_request  <= 1'b0;
      r_rnw      <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= 8'h00;
      r_pend     <= 1'b0;
      r_tmo_cnt  <= '0;
      r_err_miss <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_bit_cnt  <= w_bit_cnt_next;
      r_shift    <= w_shift_next;
      r_ptr      <= w_ptr_next;
      r_sda_oe   <= w_sda_oe_next;
      r_mack     <= w_mack_next;
      r_rd_mode  <= w_rd_mode_next;
      r_request  <= w_issue;
      r_err_miss <= w_tmo;
      if (w_issue) begin
        r_rnw  <= w_issue_rnw;
        r_addr <= r_ptr;
        if (!w_issue_rnw) r_wr_data <= w_byte;
      end
      if (w_issue) begin
        r_pend    <= 1'b1;
        r_tmo_cnt <= '0;
      end else if (w_done) begin
        r_pend <= 1'b0;
      end else if (r_pend) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end
    end
  end

  assign o_sda_oe   = r_sda_oe;
  assign o_request  = r_request;
  assign o_rnw      = r_rnw;
  assign o_addr     = r_addr;
  assign o_wr_data  = r_wr_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_err_miss = r_err_miss;

endmodule

// File: tb/tb_tcpc_i2c_slave.sv
// Directed bench: bit-banged I2C master plus a register-file model that
// logs every REQUEST and ERR_MISS.
module tb_tcpc_i2c_slave;

  localparam int HP = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       m_scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_oe, req, rnw, busy, err_miss;
  logic [7:0] addr, wd;
  logic [7:0] rf_rdata = 8'h00;
  logic       rf_ack = 1'b0;
  logic       rf_en = 1'b1;
  logic       w_sda_bus;
  logic [7:0] mem [256];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int req_cyc  = 0;
  int miss_cnt = 0;
  int miss_delay = -1;

  typedef struct packed {
    logic       rnw;
    logic [7:0] addr;
    logic [7:0] wd;
  } req_t;
  req_t req_q[$];

  typedef struct {
    logic       is_read;
    logic [7:0] ptr;
    logic [7:0] data;   // write byte, or expected bus byte for reads
  } vec_t;
  vec_t vecs[5];

  assign w_sda_bus = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  tcpc_i2c_slave #(.SLAVE_ADDR(7'h50), .ACK_TIMEOUT(4)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_scl     (m_scl),
    .i_sda     (w_sda_bus),
    .o_sda_oe  (sda_oe),
    .o_request (req),
    .o_rnw     (rnw),
    .o_addr    (addr),
    .o_wr_data (wd),
    .i_rd_data (rf_rdata),
    .i_ack     (rf_ack),
    .o_busy    (busy),
    .o_err_miss(err_miss)
  );

  // Register file: ACK one cycle after REQUEST when enabled
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rf_ack   <= req & rf_en;
    rf_rdata <= mem[addr];
  end

  always @(negedge clk) begin
    if (req) begin
      req_q.push_back('{rnw, addr, wd});
      req_cyc = cyc;
    end
    if (err_miss) begin
      miss_cnt   = miss_cnt + 1;
      miss_delay = cyc - req_cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic req_t get_req(input int i);
    if (i < req_q.size()) return req_q[i];
    return '1;
  endfunction

  task automatic cw(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic bus_start();
    m_sda = 1'b1; cw(HP);
    m_scl = 1'b1; cw(HP);
    m_sda = 1'b0; cw(HP);
    m_scl = 1'b0; cw(HP);
  endtask

  task automatic bus_stop();
    m_sda = 1'b0; cw(HP);
    m_scl = 1'b1; cw(HP);
    m_sda = 1'b1; cw(HP);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    m_sda = b; cw(HP);
    m_scl = 1'b1; cw(HP);
    s = w_sda_bus; cw(HP);
    m_scl = 1'b0; cw(HP);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(~mack, s);
  endtask

  task automatic wr_txn(input logic [7:0] ptr, input logic [7:0] d0, input logic [7:0] d1, input int n);
    logic [3:0] a;
    a = 4'h0;
    bus_start();
    write_byte(8'hA0, a[0]);
    write_byte(ptr, a[1]);
    write_byte(d0, a[2]);
    if (n > 1) write_byte(d1, a[3]);
    bus_stop();
    check("wr_bus_acks", a, 4'h0);
    $display("txn write ptr=%02h d0=%02h n=%0d reqs=%0d", ptr, d0, n, req_q.size());
  endtask

  task automatic rd_txn(input logic set_ptr, input logic [7:0] ptr, input int n,
                        output logic [7:0] b0, output logic [7:0] b1);
    logic [2:0] a;
    a  = 3'h0;
    b1 = 8'h00;
    bus_start();
    if (set_ptr) begin
      write_byte(8'hA0, a[0]);
      write_byte(ptr, a[1]);
      bus_start();
    end
    write_byte(8'hA1, a[2]);
    read_byte(n > 1, b0);
    if (n > 1) read_byte(1'b0, b1);
    bus_stop();
    check("rd_bus_acks", a, 3'h0);
    $display("txn read ptr=%02h set=%0d n=%0d b0=%02h b1=%02h reqs=%0d", ptr, set_ptr, n, b0, b1, req_q.size());
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b0, b1;
    logic       a;
    int         m0;

    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
    mem[8'h00] = 8'h77; mem[8'h01] = 8'h5C; mem[8'h04] = 8'h34; mem[8'h05] = 8'h12;
    mem[8'h11] = 8'h3C; mem[8'h20] = 8'h9E; mem[8'h30] = 8'h00; mem[8'h41] = 8'h81;

    vecs[0] = '{1'b0, 8'h80, 8'hC3};
    vecs[1] = '{1'b1, 8'h20, 8'h9E};
    vecs[2] = '{1'b0, 8'h01, 8'hFF};
    vecs[3] = '{1'b1, 8'h41, 8'h81};
    vecs[4] = '{1'b0, 8'hFE, 8'h00};

    // Reset state
    cw(3);
    check("reset_outputs", {sda_oe, req, rnw, addr, wd, busy, err_miss}, 0);
    rst = 1'b0;
    cw(5);
    check("idle_outputs", {sda_oe, req, busy, err_miss}, 0);

    // Single write, then a pointer-less read shows the pointer advanced
    req_q.delete();
    wr_txn(8'h10, 8'h5A, 8'h00, 1);
    check("wr_req_count", req_q.size(), 1);
    check("wr_req", get_req(0), {1'b0, 8'h10, 8'h5A});
    check("wr_busy_after_stop", busy, 1'b0);
    req_q.delete();
    rd_txn(1'b0, 8'h00, 1, b0, b1);
    check("ptr_after_write", {get_req(0).rnw, get_req(0).addr}, {1'b1, 8'h11});
    check("ptr_after_write_byte", b0, 8'h3C);

    // Table-driven single-byte transactions
    for (int v = 0; v < 5; v++) begin
      req_q.delete();
      m0 = miss_cnt;
      if (vecs[v].is_read) begin
        rd_txn(1'b1, vecs[v].ptr, 1, b0, b1);
        check("vec_rd_byte", b0, vecs[v].data);
        check("vec_rd_req", {get_req(0).rnw, get_req(0).addr}, {1'b1, vecs[v].ptr});
      end else begin
        wr_txn(vecs[v].ptr, vecs[v].data, 8'h00, 1);
        check("vec_wr_req", get_req(0), {1'b0, vecs[v].ptr, vecs[v].data});
      end
      check("vec_req_count", req_q.size(), 1);
      check("vec_no_miss", miss_cnt - m0, 0);
    end

    // Burst read across a repeated START
    req_q.delete();
    rd_txn(1'b1, 8'h04, 2, b0, b1);
    check("burst_bytes", {b0, b1}, 16'h3412);
    check("burst_req_count", req_q.size(), 2);
    check("burst_req0", {get_req(0).rnw, get_req(0).addr}, {1'b1, 8'h04});
    check("burst_req1", {get_req(1).rnw, get_req(1).addr}, {1'b1, 8'h05});

    // Wrong device address
    req_q.delete();
    bus_start();
    write_byte(8'h42, a);
    check("wrong_addr_nack", a, 1'b1);
    check("wrong_addr_busy", busy, 1'b1);
    bus_stop();
    check("wrong_addr_idle", busy, 1'b0);
    check("wrong_addr_no_req", req_q.size(), 0);
    $display("txn wrong-address 42 ack=%0d", a);

    // Unmapped read: no register ACK
    req_q.delete();
    rf_en = 1'b0;
    m0 = miss_cnt;
    rd_txn(1'b1, 8'h00, 1, b0, b1);
    rf_en = 1'b1;
    check("miss_byte", b0, 8'h00);
    check("miss_count", miss_cnt - m0, 1);
    check("miss_delay", miss_delay, 4);
    req_q.delete();
    rd_txn(1'b0, 8'h00, 1, b0, b1);
    check("miss_ptr_advanced", {get_req(0).rnw, get_req(0).addr}, {1'b1, 8'h01});
    check("miss_next_byte", b0, 8'h5C);

    // Pointer wrap
    req_q.delete();
    wr_txn(8'hFF, 8'h11, 8'h22, 2);
    check("wrap_req_count", req_q.size(), 2);
    check("wrap_req0", get_req(0), {1'b0, 8'hFF, 8'h11});
    check("wrap_req1", get_req(1), {1'b0, 8'h00, 8'h22});

    // Reset while the slave drives a 0 read bit
    bus_start();
    write_byte(8'hA0, a);
    write_byte(8'h30, a);
    bus_start();
    write_byte(8'hA1, a);
    check("rst_pre_drive", sda_oe, 1'b1);
    #1 rst = 1'b1;
    #1;
    check("rst_async_release", sda_oe, 1'b0);
    check("rst_busy", busy, 1'b0);
    cw(3);
    rst = 1'b0;
    m_sda = 1'b1;
    m_scl = 1'b1;
    cw(HP);
    $display("txn reset-mid-read sda_oe=%0d busy=%0d", sda_oe, busy);
    req_q.delete();
    rd_txn(1'b0, 8'h00, 1, b0, b1);
    check("rst_ptr_zero", {get_req(0).rnw, get_req(0).addr}, {1'b1, 8'h00});
    check("rst_ptr_zero_byte", b0, 8'h77);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tcpc_i2c_slave.md
# tcpc_i2c_slave

I2C slave front end for the TCPC register file. Decodes I2C transactions on oversampled SCL/SDA into the register file's single-byte REQUEST/RNW/ADDR/WR_DATA access handshake and returns RD_DATA to the bus master. It holds a register pointer with auto-increment, so one burst can read or write consecutive registers, such as the TX/RX buffer bytes or 16-bit register pairs.

## Interface
- SLAVE_ADDR, 7'h50: 7-bit I2C device address.
- ACK_TIMEOUT, 4: CLK cycles to wait for register ACK after REQUEST before declaring a miss.
- CLK  in  1  single clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- SCL_IN  in  1  raw bus clock, asynchronous to CLK.
- SDA_IN  in  1  raw bus data, asynchronous to CLK.
- SDA_OE  out  1  1 = pull SDA low (open-drain); 0 = release.
- REQUEST  out  1  one-cycle access strobe to register file.
- RNW  out  1  1 = read, 0 = write; valid with REQUEST.
- ADDR  out  8  register address; valid with REQUEST.
- WR_DATA  out  8  write byte; valid with REQUEST.
- RD_DATA  in  8  read byte; sampled in the cycle ACK=1.
- ACK  in  1  one-cycle completion pulse from register file.
- BUSY  out  1  high from START to STOP (addressed or not).
- ERR_MISS  out  1  one-cycle pulse when an access gets no ACK within ACK_TIMEOUT.

## Operation
- Sync SCL_IN/SDA_IN through 2 flops, plus a third delayed copy for edge detection. START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both are legal in any state.
- FSM states: IDLE, DEV_ADDR, DEV_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RFETCH, RSHIFT, RMACK, IGNORE.
- START from any state goes to DEV_ADDR, bit counter = 0. The pointer is kept, so a repeated START keeps it.
- Bits are shifted MSB first on SCL rising edge.
- DEV_ADDR, 8 bits:
  - Address match: drive ACK (SDA_OE=1) for the 9th clock.
  - Mismatch: go to IGNORE (SDA released until STOP/START).
- R/W = 0 path:
  - DEV_ACK goes to PTR. The 8th PTR bit loads the pointer. PTR_ACK goes to WDATA.
  - On each completed WDATA byte (8th SCL rise), issue REQUEST with RNW=0, ADDR=pointer, WR_DATA=byte. Then pointer += 1, wrapping 8'hFF to 8'h00.
  - Data bytes are always ACKed on the bus.
- R/W = 1 path:
  - During DEV_ACK, go to RFETCH: issue REQUEST with RNW=1, ADDR=pointer.
  - On ACK: load shift register from RD_DATA, pointer += 1, go to RSHIFT.
  - RSHIFT drives bits on SCL falling edges (SDA_OE = ~bit). After the 8th bit, release SDA and go to RMACK.
  - In RMACK, sample SDA on SCL rise. Master ACK (0) goes to RFETCH for the next byte. NACK (1) goes to IGNORE.
- Timeout: if ACK does not arrive within ACK_TIMEOUT cycles, pulse ERR_MISS. The pointer still increments. A read byte is returned as 8'h00.
- STOP goes to IDLE and releases SDA.

## Timing
- Reset values: SDA_OE=0, REQUEST=0, RNW=0, ADDR=0, WR_DATA=0, BUSY=0, ERR_MISS=0, pointer=0, state IDLE. Reset mid-transfer releases SDA immediately (asynchronous).
- Input latency: 3 CLK cycles from pin to edge detect.
- SDA_OE changes only in the cycle after a detected SCL fall, giving hold ≥ 1 CLK.
- REQUEST is high for exactly 1 cycle; ADDR/RNW/WR_DATA are held until the next REQUEST.
- ACK is expected 1 cycle after REQUEST. ACK arriving after the timeout window is ignored.
- A read fetch completes within ACK_TIMEOUT+2 cycles. The requirement is SCL low ≥ ACK_TIMEOUT+6 CLK cycles, i.e. 10 with defaults.
- ERR_MISS fires in the cycle the timeout expires.
- START/STOP detected in the same cycle as an SCL edge: no conflict, since the detect conditions are exclusive (SCL high required).

## Structure
- Shared package tcpc_pkg: FSM state encoding, I2C_ADDR_W=7, REG_ADDR_W=8.
- One sub-module: i2c_sync_edge (2-flop synchroniser plus rise/fall/START/STOP detect).

## Test plan
- Write: START, 0xA0, ptr 0x10, data 0x5A, STOP -> one REQUEST with RNW=0, ADDR=0x10, WR_DATA=0x5A; SDA ACKs on all 3 bytes; pointer ends at 0x11.
- Burst read: START, 0xA0, ptr 0x04, repeated START, 0xA1, read 2 bytes (ACK, then NACK) with RD_DATA 0x34, 0x12 -> REQUESTs to 0x04 and 0x05; bus sees 0x34, 0x12.
- Wrong address: START, 0x42 -> SDA released on 9th clock; no REQUEST; BUSY stays high until STOP.
- Unmapped read: pointer 0x00, no ACK from register file -> ERR_MISS pulse 4 cycles after REQUEST; bus byte 0x00; pointer becomes 0x01.
- Pointer wrap: write ptr 0xFF, then 2 data bytes -> REQUESTs at 0xFF and then 0x00.
- Reset asserted while driving a 0 read bit -> SDA_OE=0 in the same cycle; state IDLE; pointer 0.
